// File: rtl/dmem_responder.sv
// Stalling data-memory responder: valid/ready request and response channels.
// Optional access counters (rd/wr/err) enabled by DMEM_ACCESS_CNT_EN.
module dmem_responder #(
  parameter int DATA_W      = 32,
  parameter int DM_ADDRESS  = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_error
`ifdef DMEM_ACCESS_CNT_EN
  ,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count,
  output logic [15:0]           err_count
`endif
);

  localparam int IW    = DM_ADDRESS - 2;
  localparam int DEPTH = 2 ** IW;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic                  write;
    logic [2:0]            funct3;
    logic [DM_ADDRESS-1:0] addr;
    logic [DATA_W-1:0]     wdata;
  } req_t;

  state_t state;
  state_t state_nx;
  req_t   req;

  logic [3:0]        cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [IW-1:0]     idx;
  logic [DATA_W-1:0] word;
  logic [7:0]        bsel;
  logic [15:0]       hsel;
  logic [DATA_W-1:0] ld;
  logic [DATA_W-1:0] wrep;
  logic [3:0]        be;
  logic              is_b;
  logic              is_h;
  logic              is_w;
  logic              err;
  logic              accept;
  logic              access;
  logic              done;
  logic              we;

  assign idx    = req.addr[DM_ADDRESS-1:2];
  assign word   = mem[idx];
  assign accept = (state == IDLE) && req_valid;
  assign access = (state == WAIT) && (cnt == 4'd0);
  assign done   = (state == RESP) && rsp_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = WAIT;
      end
      WAIT: begin
        if (cnt == 4'd0) state_nx = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bsel = word[7:0];
    unique case (req.addr[1:0])
      2'd0: bsel = word[7:0];
      2'd1: bsel = word[15:8];
      2'd2: bsel = word[23:16];
      2'd3: bsel = word[31:24];
      default: bsel = word[7:0];
    endcase
    hsel = req.addr[1] ? word[31:16] : word[15:0];
  end

  assign is_b = (req.funct3[1:0] == 2'b00);
  assign is_h = (req.funct3[1:0] == 2'b01);
  assign is_w = (req.funct3[1:0] == 2'b10);

  // Loads: bit 2 selects zero-extension and is illegal for word size.
  // Stores: only the three signed-size encodings exist.
  always_comb begin
    ld   = '0;
    be   = 4'b0000;
    wrep = req.wdata;
    err  = 1'b0;
    unique case (1'b1)
      is_b: begin
        ld   = req.funct3[2] ? {24'd0, bsel}
                             : {{24{bsel[7]}}, bsel};
        be   = 4'b0001 << req.addr[1:0];
        wrep = {4{req.wdata[7:0]}};
      end
      is_h: begin
        ld   = req.funct3[2] ? {16'd0, hsel}
                             : {{16{hsel[15]}}, hsel};
        be   = req.addr[1] ? 4'b1100 : 4'b0011;
        wrep = {2{req.wdata[15:0]}};
        err  = req.addr[0];
      end
      is_w: begin
        ld  = word;
        be  = 4'b1111;
        err = (req.addr[1:0] != 2'b00) || req.funct3[2];
      end
      default: err = 1'b1;
    endcase
    if (req.write && req.funct3[2]) err = 1'b1;
  end

  assign we = access && req.write && !err && reset;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && be[i]) mem[idx][8*i +: 8] <= wrep[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req <= '0;
      cnt <= 4'd0;
    end else if (accept) begin
      req.write  <= req_write;
      req.funct3 <= req_funct3;
      req.addr   <= req_addr;
      req.wdata  <= req_wdata;
      cnt        <= 4'(WAIT_CYCLES);
    end else if ((state == WAIT) && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else if (access) begin
      rsp_rdata <= (req.write || err) ? '0 : ld;
      rsp_error <= err;
    end else if (done) begin
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end
  end

`ifdef DMEM_ACCESS_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_count  <= 16'd0;
      wr_count  <= 16'd0;
      err_count <= 16'd0;
    end else if (done) begin
      if (rsp_error) err_count <= sat_inc(err_count);
      else if (req.write) wr_count <= sat_inc(wr_count);
      else rd_count <= sat_inc(rd_count);
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with two wait states, one with none.
// Counter checks are compiled in when DMEM_ACCESS_CNT_EN is defined.
module tb_dmem_responder;

  localparam int AW = 9;
  localparam int W0 = 2;
  localparam int W1 = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]          reset;
  logic [1:0]          req_valid;
  logic [1:0]          req_write;
  logic [1:0]          rsp_ready;
  logic [1:0][2:0]     req_funct3;
  logic [1:0][AW-1:0]  req_addr;
  logic [1:0][31:0]    req_wdata;
  wire  [1:0]          req_ready;
  wire  [1:0]          rsp_valid;
  wire  [1:0]          rsp_error;
  wire  [1:0][31:0]    rsp_rdata;
`ifdef DMEM_ACCESS_CNT_EN
  wire  [1:0][15:0]    rd_count;
  wire  [1:0][15:0]    wr_count;
  wire  [1:0][15:0]    err_count;
`endif

  int nchk = 0;
  int nerr = 0;
  logic [32:0] sb[$];

  dmem_responder #(.DATA_W(32), .DM_ADDRESS(AW), .WAIT_CYCLES(W0)) dut0 (
    .clk(clk), .reset(reset[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_funct3(req_funct3[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_error(rsp_error[0])
`ifdef DMEM_ACCESS_CNT_EN
    , .rd_count(rd_count[0]), .wr_count(wr_count[0]),
    .err_count(err_count[0])
`endif
  );

  dmem_responder #(.DATA_W(32), .DM_ADDRESS(AW), .WAIT_CYCLES(W1)) dut1 (
    .clk(clk), .reset(reset[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_funct3(req_funct3[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_error(rsp_error[1])
`ifdef DMEM_ACCESS_CNT_EN
    , .rd_count(rd_count[1]), .wr_count(wr_count[1]),
    .err_count(err_count[1])
`endif
  );

  function automatic int wc(input int d);
    return (d == 0) ? W0 : W1;
  endfunction

  task automatic txn(input int d, input logic wr, input logic [2:0] f3,
                     input logic [AW-1:0] a, input logic [31:0] wd,
                     input logic [31:0] er, input logic ee,
                     input string nm);
    int lat;
    logic [32:0] exp;
    sb.push_back({ee, er});
    @(negedge clk);
    req_valid[d]  = 1'b1;
    req_write[d]  = wr;
    req_funct3[d] = f3;
    req_addr[d]   = a;
    req_wdata[d]  = wd;
    nchk++;
    if (req_ready[d] !== 1'b1) begin
      nerr++;
      $display("FAIL %s req_ready act=%b req=1", nm, req_ready[d]);
    end
    @(posedge clk);
    #1;
    req_valid[d]  = 1'b0;
    req_write[d]  = ~wr;
    req_funct3[d] = 3'b111;
    req_addr[d]   = a ^ 9'h1ff;
    req_wdata[d]  = ~wd;
    lat = 0;
    while (rsp_valid[d] !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    nchk++;
    if (lat != wc(d) + 1) begin
      nerr++;
      $display("FAIL %s latency act=%0d req=%0d", nm, lat, wc(d) + 1);
    end
    exp = sb.pop_front();
    nchk++;
    if (rsp_rdata[d] !== exp[31:0] || rsp_error[d] !== exp[32]) begin
      nerr++;
      $display("FAIL %s rsp act=%h/%b req=%h/%b", nm,
               rsp_rdata[d], rsp_error[d], exp[31:0], exp[32]);
    end
  endtask

  task automatic finish_rsp(input int d, input string nm);
    rsp_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    nchk++;
    if (rsp_valid[d] !== 1'b0 || rsp_rdata[d] !== 32'd0 ||
        rsp_error[d] !== 1'b0 || req_ready[d] !== 1'b1) begin
      nerr++;
      $display("FAIL %s release act=v%b d%h e%b r%b req=v0 d0 e0 r1", nm,
               rsp_valid[d], rsp_rdata[d], rsp_error[d], req_ready[d]);
    end
  endtask

  task automatic op(input int d, input logic wr, input logic [2:0] f3,
                    input logic [AW-1:0] a, input logic [31:0] wd,
                    input logic [31:0] er, input logic ee,
                    input string nm);
    txn(d, wr, f3, a, wd, er, ee, nm);
    finish_rsp(d, nm);
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      nchk++;
      if (req_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0 ||
          rsp_rdata[d] !== 32'd0 || rsp_error[d] !== 1'b0) begin
        nerr++;
        $display("FAIL reset%0d act=r%b v%b d%h e%b req=r1 v0 d0 e0", d,
                 req_ready[d], rsp_valid[d], rsp_rdata[d], rsp_error[d]);
      end
`ifdef DMEM_ACCESS_CNT_EN
      nchk++;
      if (rd_count[d] !== 16'd0 || wr_count[d] !== 16'd0 ||
          err_count[d] !== 16'd0) begin
        nerr++;
        $display("FAIL reset_cnt%0d act=%h %h %h req=0 0 0", d,
                 rd_count[d], wr_count[d], err_count[d]);
      end
`endif
    end
  endtask

  task automatic test_word_roundtrip();
    op(0, 1'b1, 3'b010, 9'h010, 32'hDEADBEEF, 32'h0, 1'b0, "sw_010");
    op(0, 1'b0, 3'b010, 9'h010, 32'h0, 32'hDEADBEEF, 1'b0, "lw_010");
  endtask

  task automatic test_byte_lanes();
    op(0, 1'b1, 3'b010, 9'h020, 32'h00000000, 32'h0, 1'b0, "sw_020");
    op(0, 1'b1, 3'b000, 9'h023, 32'hABCDEF80, 32'h0, 1'b0, "sb_023");
    op(0, 1'b1, 3'b001, 9'h020, 32'h55551234, 32'h0, 1'b0, "sh_020");
    op(0, 1'b0, 3'b010, 9'h020, 32'h0, 32'h80001234, 1'b0, "lw_020");
    op(0, 1'b0, 3'b000, 9'h023, 32'h0, 32'hFFFFFF80, 1'b0, "lb_023");
    op(0, 1'b0, 3'b100, 9'h023, 32'h0, 32'h00000080, 1'b0, "lbu_023");
    op(0, 1'b0, 3'b001, 9'h020, 32'h0, 32'h00001234, 1'b0, "lh_020");
    op(0, 1'b0, 3'b001, 9'h022, 32'h0, 32'hFFFF8000, 1'b0, "lh_022");
    op(0, 1'b0, 3'b101, 9'h022, 32'h0, 32'h00008000, 1'b0, "lhu_022");
  endtask

  task automatic test_misalign();
    op(0, 1'b1, 3'b010, 9'h030, 32'h0BADF00D, 32'h0, 1'b0, "sw_030");
    op(0, 1'b1, 3'b010, 9'h031, 32'hFFFFFFFF, 32'h0, 1'b1, "sw_031");
    op(0, 1'b0, 3'b010, 9'h030, 32'h0, 32'h0BADF00D, 1'b0, "lw_030a");
    op(0, 1'b0, 3'b001, 9'h033, 32'h0, 32'h0, 1'b1, "lh_033");
    op(0, 1'b0, 3'b011, 9'h030, 32'h0, 32'h0, 1'b1, "ld_f3_011");
    op(0, 1'b1, 3'b100, 9'h030, 32'hFFFFFFFF, 32'h0, 1'b1, "st_f3_100");
    op(0, 1'b0, 3'b010, 9'h030, 32'h0, 32'h0BADF00D, 1'b0, "lw_030b");
  endtask

  task automatic test_backpressure();
    rsp_ready[0] = 1'b0;
    txn(0, 1'b0, 3'b010, 9'h010, 32'h0, 32'hDEADBEEF, 1'b0, "bp_lw");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid[0]  = 1'b1;
      req_write[0]  = 1'b1;
      req_funct3[0] = 3'b010;
      req_addr[0]   = 9'h010;
      req_wdata[0]  = 32'h0;
      @(posedge clk);
      #1;
      nchk++;
      if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'hDEADBEEF ||
          req_ready[0] !== 1'b0) begin
        nerr++;
        $display("FAIL bp_hold%0d act=v%b d%h r%b req=v1 dDEADBEEF r0",
                 i, rsp_valid[0], rsp_rdata[0], req_ready[0]);
      end
    end
    @(negedge clk);
    req_valid[0] = 1'b0;
    finish_rsp(0, "bp_release");
    op(0, 1'b0, 3'b010, 9'h010, 32'h0, 32'hDEADBEEF, 1'b0, "bp_lw_after");
  endtask

  task automatic test_reset_mid_store();
    op(0, 1'b1, 3'b010, 9'h040, 32'h11111111, 32'h0, 1'b0, "sw_040_prior");
    @(negedge clk);
    req_valid[0]  = 1'b1;
    req_write[0]  = 1'b1;
    req_funct3[0] = 3'b010;
    req_addr[0]   = 9'h040;
    req_wdata[0]  = 32'hA5A5A5A5;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    reset[0] = 1'b0;
    #1;
    nchk++;
    if (req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0 ||
        rsp_rdata[0] !== 32'd0 || rsp_error[0] !== 1'b0) begin
      nerr++;
      $display("FAIL rst_mid act=r%b v%b d%h e%b req=r1 v0 d0 e0",
               req_ready[0], rsp_valid[0], rsp_rdata[0], rsp_error[0]);
    end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset[0] = 1'b1;
    op(0, 1'b0, 3'b010, 9'h040, 32'h0, 32'h11111111, 1'b0, "lw_040");
  endtask

  task automatic test_zero_wait_counters();
    op(1, 1'b1, 3'b010, 9'h000, 32'h12345678, 32'h0, 1'b0, "z_sw_000");
    op(1, 1'b1, 3'b010, 9'h004, 32'hCAFEF00D, 32'h0, 1'b0, "z_sw_004");
    op(1, 1'b0, 3'b010, 9'h000, 32'h0, 32'h12345678, 1'b0, "z_lw_000");
    op(1, 1'b0, 3'b010, 9'h004, 32'h0, 32'hCAFEF00D, 1'b0, "z_lw_004");
    op(1, 1'b0, 3'b100, 9'h001, 32'h0, 32'h00000056, 1'b0, "z_lbu_001");
    op(1, 1'b0, 3'b010, 9'h002, 32'h0, 32'h0, 1'b1, "z_lw_002");
`ifdef DMEM_ACCESS_CNT_EN
    nchk++;
    if (rd_count[1] !== 16'd3 || wr_count[1] !== 16'd2 ||
        err_count[1] !== 16'd1) begin
      nerr++;
      $display("FAIL z_counts act=%0d %0d %0d req=3 2 1",
               rd_count[1], wr_count[1], err_count[1]);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 2'b00;
    req_valid  = 2'b00;
    req_write  = 2'b00;
    rsp_ready  = 2'b11;
    req_funct3 = '0;
    req_addr   = '0;
    req_wdata  = '0;
    #12;
    test_reset();
    @(negedge clk);
    reset = 2'b11;
    test_word_roundtrip();
    test_byte_lanes();
    test_misalign();
    test_backpressure();
    test_reset_mid_store();
    test_zero_wait_counters();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder (target side) for the core's load/store port. It accepts one request at a time over a valid/ready handshake.
- Inserts a programmable number of wait states, then performs a byte, halfword or word access.
- Returns read data or a completion over a second valid/ready handshake.
- Replaces the zero-latency data memory so the core can be verified against a realistic, stalling memory.

Parameters:
- DATA_W, 32, data width in bits (fixed at 32; byte lanes assume 4 bytes).
- DM_ADDRESS, 9, byte-address width; storage depth is 2^(DM_ADDRESS-2) words.
- WAIT_CYCLES, 2, wait states inserted between request acceptance and memory access (0..15).

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-low reset.
- req_valid, input, 1, request present.
- req_ready, output, 1, responder can accept a request.
- req_write, input, 1, 1 = store, 0 = load.
- req_funct3, input, 3, access size/sign, using RISC-V funct3 encoding.
- req_addr, input, DM_ADDRESS, byte address.
- req_wdata, input, DATA_W, store data, right-aligned.
- rsp_valid, output, 1, response present.
- rsp_ready, input, 1, requester accepts the response.
- rsp_rdata, output, DATA_W, load result, extended to 32 bits; 0 for stores and errors.
- rsp_error, output, 1, misaligned address or illegal funct3; no memory side effect.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0, wait counter=0.
  - Storage array contents are not cleared.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On a rising edge with req_valid=1, capture write, funct3, addr and wdata; load counter=WAIT_CYCLES; go to WAIT.
- WAIT:
  - req_ready=0.
  - If counter!=0, decrement.
  - If counter==0, perform the access on that edge, register rsp_rdata/rsp_error, and go to RESP.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_error are held stable.
  - On an edge with rsp_ready=1: go to IDLE, clear rsp_valid, rsp_rdata and rsp_error.
  - No new request is accepted in the same cycle.
- Latency: rsp_valid rises WAIT_CYCLES+1 edges after the accepting edge. Minimum throughput is one transaction per WAIT_CYCLES+3 cycles.
- Loads:
  - funct3 000 LB: sign-extend byte addr[1:0].
  - 001 LH: sign-extend halfword addr[1].
  - 010 LW: full word.
  - 100 LBU and 101 LHU: zero-extend.
- Stores:
  - 000 SB writes byte lane addr[1:0] from wdata[7:0].
  - 001 SH writes halfword lane addr[1] from wdata[15:0].
  - 010 SW writes the full word.
  - Unwritten lanes are unchanged.
- Word index is addr[DM_ADDRESS-1:2]. The address space is exactly the storage size, so no out-of-range case exists.
- Error conditions:
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - Loads with funct3 011, 110 or 111.
  - Stores with funct3 other than 000, 001 or 010.
- On error: no write, rsp_rdata=0, rsp_error=1; the response handshake is otherwise normal.
- Request inputs are sampled only on the accepting edge; changes afterwards have no effect.
- Reset mid-operation:
  - If reset is asserted in WAIT, the pending store is dropped and no array write occurs.
  - If reset is asserted in RESP, the response is discarded; a write already committed stays committed.
- Holding rsp_ready=1 continuously is legal; each response is then valid for exactly one cycle.

Optional Feature:
- Macro: DMEM_ACCESS_CNT_EN.
- When defined, adds three outputs, each 16 bits wide:
  - rd_count: completed non-error loads.
  - wr_count: completed non-error stores.
  - err_count: error responses.
- Each counter increments on the edge the response handshake completes and saturates at 16'hFFFF. Reset clears them to 0.
- When not defined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Word round trip, WAIT_CYCLES=2: SW addr 0x010 data 0xDEADBEEF, then LW 0x010. Required: rsp_rdata=0xDEADBEEF, rsp_error=0, and rsp_valid rising exactly 3 edges after each acceptance.
- Byte lanes: SW 0x020 data 0x00000000, then SB 0x023 data 0x80, then SH 0x020 data 0x1234. Required:
  - LW 0x020 returns 0x80001234.
  - LB 0x023 returns 0xFFFFFF80.
  - LBU 0x023 returns 0x00000080.
  - LH 0x020 returns 0x00001234.
- Misalignment: SW 0x031 data 0xFFFFFFFF, then LW 0x030. Required: the store gives rsp_error=1 and the memory word is unchanged. LH 0x033 gives rsp_error=1 and rsp_rdata=0.
- Backpressure: hold rsp_ready=0 for 5 cycles during an LW. Required: rsp_valid stays 1 with stable data, req_ready stays 0, and a second req_valid is ignored until the handshake completes.
- Reset mid-store: SW 0x040 data 0xA5A5A5A5 with reset pulsed low during WAIT, then LW 0x040. Required: the prior value is returned and outputs were at reset values immediately after the pulse.
- WAIT_CYCLES=0, with DMEM_ACCESS_CNT_EN defined, running 3 loads, 2 stores and 1 error. Required: latency is 1 edge, rd_count=3, wr_count=2, err_count=1.
